// File: rtl/payload_byte_feeder_pkg.sv
// -----------------------------------------------------------------------------
// payload_feeder_pkg
//   Shared constants and types for the payload byte feeder: byte width, class
//   LUT depth, FSM state encoding and the lane-index width helper.
// -----------------------------------------------------------------------------
package payload_feeder_pkg;

  localparam int PBF_BYTE_W = 8;
  localparam int LUT_DEPTH  = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOD   = 2'd1,
    ST_SHIFT = 2'd2
  } pbf_state_e;

  // Width of a lane index for a word of data_w bits; never narrower than 1.
  function automatic int lane_idx_width(input int data_w);
    int lanes;
    lanes = data_w / PBF_BYTE_W;
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/payload_byte_feeder_if.sv
// -----------------------------------------------------------------------------
// payload_byte_feeder_if
//   Payload word stream from the packet datapath into the feeder.
//   Ports / signals:
//     tdata  - payload word, byte lane 0 (bits [7:0]) is the first byte
//     tkeep  - per-lane valid, contiguous from lane 0
//     tlast  - last word of packet
//     tvalid - word valid
//     tready - word accepted when tvalid & tready
//   Modports: master (datapath side), slave (feeder side).
// -----------------------------------------------------------------------------
interface payload_byte_feeder_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/payload_byte_feeder_class_lut.sv
// -----------------------------------------------------------------------------
// class_lut
//   256-entry byte -> char-class bitmap table. One synchronous write port and
//   one registered read port. Table contents are not reset; only the read
//   register is, so the class lines come up quiet.
//   Ports:
//     clk, rst          clock, synchronous active-high reset (read reg only)
//     we/wr_addr/wr_data write strobe, byte address, class bitmap
//     re/rd_addr        lookup strobe and byte address
//     rd_data           bitmap of the byte looked up in the previous cycle;
//                       zero in cycles that follow no lookup
// -----------------------------------------------------------------------------
module class_lut
  import payload_feeder_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [7:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [7:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Zero when no lookup so class lines are only non-zero alongside en.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/payload_byte_feeder.sv
// -----------------------------------------------------------------------------
// payload_byte_feeder
//   Transmit side of the payload-engine char-class interface. Accepts payload
//   words, serializes them one byte per clock (lane 0 first), maps each byte
//   through a programmable class LUT and drives the shared sod/en/class_vec/eod
//   lines consumed by the NFA engine array.
//
//   Optional feature macro: PBF_CASE_FOLD_EN
//     defined   - with cfg_nocase=1 (sampled at SOD) bytes 0x41-0x5A are
//                 folded to lower case before the LUT lookup
//     undefined - bytes address the LUT raw; cfg_nocase is ignored
//
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     s            payload word stream (slave modport)
//     cfg_we/cfg_addr/cfg_data  LUT write; accepted only while cfg_ready
//     cfg_nocase   case-fold enable
//     cfg_ready    high in IDLE
//     sod          one-cycle start-of-data pulse, clears the engines
//     en           byte strobe, class_vec valid
//     class_vec    class bitmap of the current byte
//     eod          with en on the final byte of a packet
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for the first word of a packet; LUT writable
//   SOD   | one cycle of sod=1 before the packet's first byte
//   SHIFT | one byte lookup per cycle; refills holding reg between words
// -----------------------------------------------------------------------------
module payload_byte_feeder
  import payload_feeder_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int NUM_CLASSES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  payload_byte_feeder_if.slave   s,
  input  logic                   cfg_we,
  input  logic [7:0]             cfg_addr,
  input  logic [NUM_CLASSES-1:0] cfg_data,
  input  logic                   cfg_nocase,
  output logic                   cfg_ready,
  output logic                   sod,
  output logic                   en,
  output logic [NUM_CLASSES-1:0] class_vec,
  output logic                   eod
);

  localparam int LANES = DATA_W / PBF_BYTE_W;
  localparam int LW    = lane_idx_width(DATA_W);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SOD   = ST_SOD;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;

  logic [1:0] state;

  logic                             hold_valid;
  logic [LANES-1:0][PBF_BYTE_W-1:0] hold_bytes;
  logic [LANES-1:0]                 hold_keep;
  logic                             hold_last;
  logic [LW-1:0]                    lane;

  logic [LW-1:0]         last_lane;
  logic                  keep_any;
  logic                  sel;
  logic                  last_sel;
  logic                  word_done;
  logic                  pkt_end;
  logic                  accept;
  logic [PBF_BYTE_W-1:0] cur_byte;
  logic [7:0]            lut_addr;
  logic                  lut_we;

  // Keep is contiguous from lane 0, so the highest set bit is the last byte.
  always_comb begin
    last_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (hold_keep[i]) begin
        last_lane = LW'(i);
      end
    end
  end

  assign keep_any  = |hold_keep;
  assign sel       = (state == S_SHIFT) && hold_valid && keep_any;
  assign last_sel  = sel && (lane == last_lane);
  // An all-zero keep word has no bytes; it finishes immediately.
  assign word_done = (state == S_SHIFT) && hold_valid && (!keep_any || (lane == last_lane));
  assign pkt_end   = word_done && hold_last;

  // In SHIFT the next word is taken in the same cycle the last byte of the
  // current one is selected (zero bubble), or any time the holding reg is
  // empty after a source gap.
  assign s.tready = !rst &&
                    ((state == S_IDLE) ||
                     ((state == S_SHIFT) && (!hold_valid || (last_sel && !hold_last))));
  assign accept   = s.tvalid && s.tready;

  assign cfg_ready = (state == S_IDLE);
  assign lut_we    = cfg_we && (state == S_IDLE);

  assign cur_byte = hold_bytes[lane];

`ifdef PBF_CASE_FOLD_EN
  logic nocase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nocase_q <= 1'b0;
    end else if (state == S_SOD) begin
      nocase_q <= cfg_nocase;
    end
  end

  always_comb begin
    lut_addr = cur_byte;
    if (nocase_q && (cur_byte >= 8'h41) && (cur_byte <= 8'h5A)) begin
      lut_addr = cur_byte | 8'h20;
    end
  end
`else
  logic unused_nocase;

  assign unused_nocase = cfg_nocase;
  assign lut_addr      = cur_byte;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_valid <= 1'b0;
      lane       <= '0;
      sod        <= 1'b0;
      en         <= 1'b0;
      eod        <= 1'b0;
    end else begin
      sod <= (state == S_IDLE) && accept;
      en  <= sel;
      eod <= last_sel && hold_last;

      case (state)
        S_IDLE:  if (accept) state <= S_SOD;
        S_SOD:   state <= S_SHIFT;
        S_SHIFT: if (pkt_end) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        hold_valid <= 1'b1;
        lane       <= '0;
      end else if (word_done) begin
        hold_valid <= 1'b0;
        lane       <= '0;
      end else if (sel) begin
        lane <= lane + LW'(1);
      end
    end
  end

  // Payload storage carries no reset; hold_valid qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_bytes <= s.tdata;
      hold_keep  <= s.tkeep;
      hold_last  <= s.tlast;
    end
  end

  class_lut #(
    .WIDTH (NUM_CLASSES)
  ) u_class_lut (
    .clk     (clk),
    .rst     (rst),
    .we      (lut_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .re      (sel),
    .rd_addr (lut_addr),
    .rd_data (class_vec)
  );

endmodule

// File: tb/tb_payload_byte_feeder.sv
`timescale 1ns/1ps
module tb_payload_byte_feeder;

  localparam int DATA_W = 64;
  localparam int NC     = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [7:0]    cfg_addr = '0;
  logic [NC-1:0] cfg_data = '0;
  logic          cfg_nocase = 1'b0;
  logic          cfg_ready, sod, en, eod;
  logic [NC-1:0] class_vec;

  payload_byte_feeder_if #(.DATA_W(DATA_W)) bus ();

  payload_byte_feeder #(
    .DATA_W      (DATA_W),
    .NUM_CLASSES (NC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_nocase (cfg_nocase),
    .cfg_ready  (cfg_ready),
    .sod        (sod),
    .en         (en),
    .class_vec  (class_vec),
    .eod        (eod)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [NC-1:0] lut_m [256];
  logic [7:0]    exp_b [$];

  typedef struct packed {
    logic          sod;
    logic          en;
    logic          eod;
    logic [NC-1:0] cls;
  } obs_t;

  obs_t obs_q [$];
  bit   logging = 1'b0;

  always @(negedge clk) if (logging) obs_q.push_back({sod, en, eod, class_vec});

  int a_sod, a_en, a_eod, a_first_en, a_last_en, a_first_eod, a_sod2, a_overlap;
  logic [NC-1:0] a_cls [$];

  task automatic analyze();
    a_sod = 0; a_en = 0; a_eod = 0; a_overlap = 0;
    a_first_en = -1; a_last_en = -1; a_first_eod = -1; a_sod2 = -1;
    a_cls.delete();
    foreach (obs_q[i]) begin
      if (obs_q[i].sod) begin
        if (a_sod == 1) a_sod2 = i;
        a_sod++;
      end
      if (obs_q[i].en) begin
        if (a_first_en < 0) a_first_en = i;
        a_last_en = i;
        a_en++;
        a_cls.push_back(obs_q[i].cls);
      end
      if (obs_q[i].eod) begin
        if (a_first_eod < 0) a_first_eod = i;
        a_eod++;
      end
      if (obs_q[i].sod && obs_q[i].en) a_overlap++;
    end
  endtask

  function automatic int seq_hits();
    int h = 0;
    if (exp_b.size() != a_cls.size()) return -1;
    foreach (exp_b[i]) if (a_cls[i] === lut_m[exp_b[i]]) h++;
    return h;
  endfunction

  task automatic begin_log();
    obs_q.delete();
    logging = 1'b1;
  endtask

  task automatic end_log(input int n);
    repeat (n) @(negedge clk);
    logging = 1'b0;
    analyze();
  endtask

  // Called just after a negedge; returns at the negedge following the write.
  task automatic lut_wr(input logic [7:0] a, input logic [NC-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    lut_m[a] = d;
  endtask

  // Called just after a negedge. Withholds tvalid for hold_low cycles in which
  // the DUT is ready, then offers the word. Returns at the negedge after the
  // accepting edge.
  task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input int hold_low);
    int n = 0;
    int guard = 0;
    bus.tvalid = 1'b0;
    while (n < hold_low && guard < 200) begin
      if (bus.tready) n++;
      @(negedge clk);
      guard++;
    end
    bus.tdata = d; bus.tkeep = k; bus.tlast = l; bus.tvalid = 1'b1;
    while (!bus.tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("hs_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.tvalid = 1'b0; bus.tdata = '0; bus.tkeep = '0; bus.tlast = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tready", bus.tready, 1'b0);
    chk("rst_sod", sod, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_eod", eod, 1'b0);
    chk("rst_class", class_vec, 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_tready", bus.tready, 1'b1);
    chk("post_rst_cfg_ready", cfg_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      lut_wr(b, {b, ~b, b, 8'h5A, b, ~b, b, 8'hA5});
    end

    // T1: "Co", keep 0x03, last
    lut_wr(8'h43, 64'h0000_4000_0000_0000);
    lut_wr(8'h6F, 64'h0000_0000_0004_0000);
    send_word(64'h0000_0000_0000_6F43, 8'h03, 1'b1, 0);
    chk("t1_sod", {sod, en}, 2'b10);
    chk("t1_sod_tready", bus.tready, 1'b0);
    chk("t1_sod_cfg_ready", cfg_ready, 1'b0);
    @(negedge clk);
    chk("t1_lookup", {sod, en}, 2'b00);
    @(negedge clk);
    chk("t1_b0", {en, eod, class_vec}, {2'b10, 64'h0000_4000_0000_0000});
    @(negedge clk);
    chk("t1_b1", {en, eod, class_vec}, {2'b11, 64'h0000_0000_0004_0000});
    chk("t1_idle_cfg_ready", cfg_ready, 1'b1);
    @(negedge clk);
    chk("t1_after", {en, eod, class_vec}, {2'b00, 64'h0});

    // T2: 8 + 3 bytes back to back
    begin_log();
    send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b0, 0);
    send_word(64'h0000_0000_0063_6261, 8'h07, 1'b1, 0);
    end_log(16);
    exp_b.delete();
    for (int i = 0; i < 8; i++) exp_b.push_back(8'(8'h30 + i));
    exp_b.push_back(8'h61); exp_b.push_back(8'h62); exp_b.push_back(8'h63);
    chk("t2_en_count", 64'(a_en), 64'd11);
    chk("t2_no_bubble", 64'(a_last_en - a_first_en), 64'd10);
    chk("t2_sod_count", 64'(a_sod), 64'd1);
    chk("t2_eod_pos", {32'(a_eod), 32'(a_first_eod)}, {32'd1, 32'(a_last_en)});
    chk("t2_bytes", 64'(seq_hits()), 64'd11);

    // T3: two packets back to back
    begin_log();
    send_word(64'h0000_0000_0000_3231, 8'h03, 1'b1, 0);
    send_word(64'h0000_0000_0035_3433, 8'h07, 1'b1, 0);
    end_log(12);
    exp_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    chk("t3_sod_count", 64'(a_sod), 64'd2);
    chk("t3_sod_en_overlap", 64'(a_overlap), 64'd0);
    chk("t3_sod_after_eod", (a_sod2 > a_first_eod) ? 1'b1 : 1'b0, 1'b1);
    chk("t3_eod_count", 64'(a_eod), 64'd2);
    chk("t3_bytes", 64'(seq_hits()), 64'd5);

    // T4: 5-cycle source gap between words
    begin_log();
    send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b0, 0);
    send_word(64'h0000_0000_0000_3938, 8'h03, 1'b1, 5);
    end_log(14);
    exp_b.delete();
    for (int i = 0; i < 10; i++) exp_b.push_back(8'(8'h30 + i));
    chk("t4_gap_cycles", 64'(a_last_en - a_first_en + 1 - a_en), 64'd5);
    chk("t4_sod_count", 64'(a_sod), 64'd1);
    chk("t4_bytes", 64'(seq_hits()), 64'd10);

    // T5: LUT write attempted while shifting is dropped
    send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b1, 0);
    chk("t5_cfg_ready_busy", cfg_ready, 1'b0);
    cfg_we = 1'b1; cfg_addr = 8'h6F; cfg_data = '1;
    repeat (4) @(negedge clk);
    cfg_we = 1'b0;
    repeat (10) @(negedge clk);
    begin_log();
    send_word(64'h0000_0000_0000_006F, 8'h01, 1'b1, 0);
    end_log(6);
    chk("t5_old_bitmap", (a_cls.size() == 1) ? a_cls[0] : 64'hDEAD, 64'h0000_0000_0004_0000);

    // T6: case fold around the A-Z boundaries
    cfg_nocase = 1'b1;
    begin_log();
    send_word(64'h0000_004D_5B5A_4140, 8'h1F, 1'b1, 0);
    cfg_nocase = 1'b0;
    end_log(10);
`ifdef PBF_CASE_FOLD_EN
    exp_b = '{8'h40, 8'h61, 8'h7A, 8'h5B, 8'h6D};
    chk("t6_fold_4d", (a_cls.size() == 5) ? a_cls[4] : 64'hDEAD, lut_m[8'h6D]);
`else
    exp_b = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h4D};
    chk("t6_raw_4d", (a_cls.size() == 5) ? a_cls[4] : 64'hDEAD, lut_m[8'h4D]);
`endif
    chk("t6_bytes", 64'(seq_hits()), 64'd5);

    // empty last word after a full word: no eod
    begin_log();
    send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b0, 0);
    send_word(64'h0, 8'h00, 1'b1, 0);
    end_log(14);
    chk("k0_en_count", 64'(a_en), 64'd8);
    chk("k0_no_eod", 64'(a_eod), 64'd0);

    // single empty packet: sod, no bytes, back to IDLE
    begin_log();
    send_word(64'h0, 8'h00, 1'b1, 0);
    end_log(8);
    chk("k0_pkt", {32'(a_sod), 32'(a_en)}, {32'd1, 32'd0});
    chk("k0_idle_tready", bus.tready, 1'b1);

    // reset in the middle of SHIFT
    send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("mr_pre_en", en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_outputs", {sod, en, eod, class_vec}, {3'b000, 64'h0});
    rst = 1'b0;
    #1;
    chk("mr_tready", {bus.tready, cfg_ready}, 2'b11);
    begin_log();
    end_log(12);
    chk("mr_pkt_lost", 64'(a_en + a_sod), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
